// File: rtl/hs_pipe_ctrl.sv
// hs_pipe_ctrl: token FIFO bridging an upstream and a downstream
// handshake link, four-phase (PROTO=0) or two-phase (PROTO=1).
module hs_pipe_ctrl #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int PROTO = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_in,
    input  logic [WIDTH-1:0]             data_in,
    output logic                         ack_in,
    output logic                         req_out,
    output logic [WIDTH-1:0]             data_out,
    input  logic                         ack_out,
    output logic [DEPTH-1:0]             ctrl_out,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IN_IDLE, IN_ACK} in_state_e;
    typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_WAIT} out_state_e;

    in_state_e        in_q, in_d;
    out_state_e       out_q, out_d;
    logic             tog_q, tog_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             push;
    logic             pop;
    logic             ack_hit;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Full is judged on the registered count, so a pop on the same
    // edge never frees a slot for a push until the following edge.
    assign full    = (cnt_q == CW'(DEPTH));
    assign ack_in  = (in_q == IN_ACK);
    assign ack_hit = (PROTO == 0) ? ack_out : (ack_out == tog_q);

    // In two-phase mode IN_ACK simply encodes the ack_in level.
    always_comb begin
        in_d = in_q;
        push = 1'b0;
        if (PROTO == 0) begin
            unique case (in_q)
                IN_IDLE: begin
                    if (req_in && !full) begin
                        push = 1'b1;
                        in_d = IN_ACK;
                    end
                end
                IN_ACK: begin
                    if (!req_in) in_d = IN_IDLE;
                end
                default: in_d = IN_IDLE;
            endcase
        end else if ((req_in != ack_in) && !full) begin
            push = 1'b1;
            in_d = ack_in ? IN_IDLE : IN_ACK;
        end
    end

    always_comb begin
        out_d  = out_q;
        tog_d  = tog_q;
        dout_d = dout_q;
        pop    = 1'b0;
        unique case (out_q)
            OUT_IDLE: begin
                if (cnt_q != '0) begin
                    out_d  = OUT_REQ;
                    tog_d  = ~tog_q;
                    dout_d = mem_q[rptr_q];
                end
            end
            OUT_REQ: begin
                if (ack_hit) begin
                    pop   = 1'b1;
                    out_d = (PROTO == 0) ? OUT_WAIT : OUT_IDLE;
                end
            end
            OUT_WAIT: begin
                if (!ack_out) out_d = OUT_IDLE;
            end
            default: out_d = OUT_IDLE;
        endcase
    end

    assign wptr_d = push ? nxt(wptr_q) : wptr_q;
    assign rptr_d = pop ? nxt(rptr_q) : rptr_q;
    assign cnt_d  = cnt_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            in_q   <= IN_IDLE;
            out_q  <= OUT_IDLE;
            tog_q  <= 1'b0;
            dout_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            in_q   <= in_d;
            out_q  <= out_d;
            tog_q  <= tog_d;
            dout_q <= dout_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= data_in;
    end

    always_comb begin
        ctrl_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ctrl_out[i] = (cnt_q > CW'(i));
        end
    end

    assign req_out  = (PROTO == 0) ? (out_q == OUT_REQ) : tog_q;
    assign data_out = dout_q;
    assign count    = cnt_q;

endmodule

// File: doc/hs_pipe_ctrl.md
HS_PIPE_CTRL -- requirements
Module: hs_pipe_ctrl

Interface
REQ-001 Parameter WIDTH, default 2, data payload width in bits.
REQ-002 Parameter DEPTH, default 4, token buffer depth (>=2).
REQ-003 Parameter PROTO, default 0, 0 = four-phase return-to-zero handshake, 1 = two-phase transition handshake.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 req_in  input  1  upstream request.
REQ-007 data_in  input  WIDTH  upstream payload, valid with req_in.
REQ-008 ack_in  output  1  upstream acknowledge.
REQ-009 req_out  output  1  downstream request.
REQ-010 data_out  output  WIDTH  downstream payload, head token.
REQ-011 ack_out  input  1  downstream acknowledge.
REQ-012 ctrl_out  output  DEPTH  occupancy thermometer: ctrl_out[i]=1 iff count>i.
REQ-013 count  output  $clog2(DEPTH+1)  tokens held.

Function
REQ-014 All inputs SHALL be synchronous to clk; no internal synchronizers.
REQ-015 Input FSM (PROTO=0): IN_IDLE -> IN_ACK on an edge with req_in=1 and count<DEPTH; that edge writes data_in to tail; ack_in=1 in IN_ACK.
REQ-016 IN_ACK -> IN_IDLE on an edge with req_in=0; ack_in=0 after that edge.
REQ-017 PROTO=1: push on an edge with req_in!=ack_in and count<DEPTH; ack_in toggles on that edge; no return-to-zero phase.
REQ-018 Full (count=DEPTH): push SHALL be refused, ack_in held unchanged, even if a pop occurs on the same edge; push accepted on the next edge.
REQ-019 Output FSM (PROTO=0): OUT_IDLE -> OUT_REQ on an edge with count>0; req_out=1 and data_out=head in OUT_REQ.
REQ-020 OUT_REQ -> OUT_WAIT on an edge with ack_out=1; that edge pops the head; req_out=0 in OUT_WAIT.
REQ-021 OUT_WAIT -> OUT_IDLE on an edge with ack_out=0.
REQ-022 PROTO=1: when req_out==ack_out and count>0, req_out toggles; pop on the edge where ack_out becomes equal to req_out.
REQ-023 data_out SHALL be stable while a request is outstanding (req_out!=ack_out in PROTO=1, OUT_REQ in PROTO=0).
REQ-024 Simultaneous push and pop (count not full) SHALL leave count unchanged and preserve FIFO order.
REQ-025 Latency: token pushed at edge k into empty buffer -> req_out asserted/toggled after edge k+1.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-027 ack_out activity outside OUT_REQ/OUT_WAIT (PROTO=0) or when count=0 (PROTO=1) SHALL be ignored.

Reset
REQ-028 On an edge with rst=0: ack_in=0, req_out=0, data_out=0, ctrl_out=0, count=0, pointers=0, both FSMs idle.
REQ-029 Reset SHALL take priority over all handshakes; tokens in flight are discarded.
REQ-030 req_in=1 held across reset release (PROTO=0) SHALL be accepted on the first edge with rst=1.
REQ-031 Storage contents need not be cleared; only data_out is reset.

Verification
REQ-032 PROTO=0, WIDTH=2: push 00,01,10,11 with ack_out auto-responding one cycle later -> data_out sequence 00,01,10,11, count returns to 0.
REQ-033 DEPTH=4, ack_out held 0: five requests -> four accepted, ctrl_out=4'b1111, fifth ack_in stays 0 until first pop, then accepted next edge.
REQ-034 Single token into empty buffer pushed at edge k -> req_out=1 after edge k+1, ctrl_out=4'b0001.
REQ-035 Continuous streaming, count=2 with push and pop on same edge -> count stays 2, order preserved across pointer wrap (>=10 tokens).
REQ-036 rst=0 asserted with count=3 and req_out=1 -> next edge all outputs 0; after release, fresh token 10 appears first on data_out.
REQ-037 PROTO=1: toggling req_in with data 01,10 -> ack_in toggles twice, req_out toggles per token, data_out 01 then 10.
